// File: rtl/fetch_pred_64_pkg.sv
// Y86-64 shared definitions: instruction codes, status encodings, bubble
// values and per-icode decode helpers used by the fetch stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0100;
    localparam logic [3:0] STAT_INS = 4'b1000;

    localparam logic [3:0] R_NONE       = 4'hF;
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                instr_len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    instr_len = 4'd2;
            I_JXX, I_CALL:                       instr_len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        instr_len = 4'd10;
            default:                             instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:              need_regids = 1'b1;
            default:                             need_regids = 1'b0;
        endcase
    endfunction

    // valC sits after the register byte for moves, directly after byte0 for jumps/calls
    function automatic logic valc_after_regs(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        valc_after_regs = 1'b1;
            default:                             valc_after_regs = 1'b0;
        endcase
    endfunction

    function automatic logic valc_after_op(input logic [3:0] icode);
        case (icode)
            I_JXX, I_CALL:                       valc_after_op = 1'b1;
            default:                             valc_after_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_pred_64_if.sv
// Bundle between the fetch stage and its surroundings: imem window,
// pipeline control, M/W redirect feedback and the D register outputs.
interface fetch_pred_64_if #(parameter int ADDR_W = 64);
    logic [ADDR_W-1:0] f_pc;
    logic [79:0]       instr_bytes;
    logic              F_stall;
    logic              D_stall;
    logic              D_bubble;
    logic [3:0]        M_icode;
    logic [3:0]        M_ifun;
    logic              M_cnd;
    logic              M_pred_taken;
    logic [ADDR_W-1:0] M_alt_pc;
    logic [ADDR_W-1:0] M_pc;
    logic [3:0]        W_icode;
    logic [ADDR_W-1:0] W_valM;
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [3:0]        D_rA;
    logic [3:0]        D_rB;
    logic [ADDR_W-1:0] D_valC;
    logic [ADDR_W-1:0] D_valP;
    logic [ADDR_W-1:0] D_pc;
    logic [ADDR_W-1:0] D_alt_pc;
    logic              D_pred_taken;
    logic [3:0]        D_stat;

    modport master (
        output f_pc, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_pc,
               D_alt_pc, D_pred_taken, D_stat,
        input  instr_bytes, F_stall, D_stall, D_bubble, M_icode, M_ifun,
               M_cnd, M_pred_taken, M_alt_pc, M_pc, W_icode, W_valM
    );

    modport slave (
        input  f_pc, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_pc,
               D_alt_pc, D_pred_taken, D_stat,
        output instr_bytes, F_stall, D_stall, D_bubble, M_icode, M_ifun,
               M_cnd, M_pred_taken, M_alt_pc, M_pc, W_icode, W_valM
    );
endinterface

// File: rtl/fetch_pred_64_bht.sv
// Bimodal branch history table: 2-bit saturating counters, combinational
// read of the taken bit, one update port; reads see the pre-update value.
module bht_2bit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    logic [1:0] ctr_r [ENTRIES];

    assign rd_taken = ctr_r[rd_idx][1];

    // Counter array: reset to weakly taken, saturating train on resolved jumps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b10;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr_r[upd_idx] != 2'b11) ctr_r[upd_idx] <= ctr_r[upd_idx] + 2'b01;
            end else begin
                if (ctr_r[upd_idx] != 2'b00) ctr_r[upd_idx] <= ctr_r[upd_idx] - 2'b01;
            end
        end
    end
endmodule

// File: rtl/fetch_pred_64.sv
// Y86-64 fetch stage: PC select, decode/align, status, direction prediction
// with predicted-PC register, sticky halt and the D pipeline register.
module fetch_pred_64
    import y86_pkg::*;
#(
    parameter int              ADDR_W      = 64,
    parameter int              IMEM_BYTES  = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int              PRED_MODE   = 1,
    parameter int              BHT_ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_pred_64_if.master    bus
);
    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic [ADDR_W-1:0] pred_pc_r;
    logic              halted_r;
    logic              mispredict_s, ret_s, redirect_s, load_s, bubble_s;
    logic [ADDR_W-1:0] f_pc_s, valc_s, valp_s, pred_next_s, alt_pc_s;
    logic [3:0]        icode_s, ifun_s, ra_s, rb_s, len_s, stat_s;
    logic [63:0]       c_regs_s, c_op_s;
    logic [ADDR_W:0]   end_s;
    logic              pred_taken_s, bht_taken_s, bht_upd_s, unused_s;

    assign mispredict_s = (bus.M_icode == I_JXX) && (bus.M_cnd != bus.M_pred_taken);
    assign ret_s        = (bus.W_icode == I_RET);
    assign redirect_s   = mispredict_s || ret_s;
    assign icode_s      = bus.instr_bytes[7:4];
    assign ifun_s       = bus.instr_bytes[3:0];
    assign c_regs_s     = bus.instr_bytes[79:16];
    assign c_op_s       = bus.instr_bytes[71:8];
    assign bht_upd_s    = (bus.M_icode == I_JXX) && (bus.M_ifun != 4'h0);
    assign bus.f_pc     = f_pc_s;

    // PC select: mispredict recovery beats return address beats prediction
    always_comb begin
        f_pc_s = pred_pc_r;
        if (mispredict_s) begin
            f_pc_s = bus.M_alt_pc;
        end else if (ret_s) begin
            f_pc_s = bus.W_valM;
        end else begin
            f_pc_s = pred_pc_r;
        end
    end

    // Decode/align fields, length and status of the byte window at f_pc
    always_comb begin
        ra_s   = R_NONE;
        rb_s   = R_NONE;
        valc_s = {ADDR_W{1'b0}};
        if (need_regids(icode_s)) begin
            ra_s = bus.instr_bytes[15:12];
            rb_s = bus.instr_bytes[11:8];
        end else begin
            ra_s = R_NONE;
            rb_s = R_NONE;
        end
        if (valc_after_regs(icode_s)) begin
            valc_s = c_regs_s[ADDR_W-1:0];
        end else if (valc_after_op(icode_s)) begin
            valc_s = c_op_s[ADDR_W-1:0];
        end else begin
            valc_s = {ADDR_W{1'b0}};
        end
        len_s  = instr_len(icode_s);
        valp_s = f_pc_s + ADDR_W'(len_s);
        end_s  = {1'b0, f_pc_s} + (ADDR_W+1)'(len_s);
        if (end_s > (ADDR_W+1)'(IMEM_BYTES)) begin
            stat_s = STAT_ADR;
        end else if (icode_s == I_HALT) begin
            stat_s = STAT_HLT;
        end else if (icode_s > I_POPQ) begin
            stat_s = STAT_INS;
        end else begin
            stat_s = STAT_AOK;
        end
    end

    // Direction prediction: unconditional jumps and calls always follow valC
    always_comb begin
        pred_taken_s = 1'b0;
        pred_next_s  = valp_s;
        alt_pc_s     = valp_s;
        if (icode_s == I_JXX) begin
            pred_taken_s = (ifun_s == 4'h0) ? 1'b1 : bht_taken_s;
            pred_next_s  = pred_taken_s ? valc_s : valp_s;
            alt_pc_s     = pred_taken_s ? valp_s : valc_s;
        end else if (icode_s == I_CALL) begin
            pred_next_s  = valc_s;
        end else begin
            pred_next_s  = valp_s;
        end
    end

    generate
        if (PRED_MODE == 1) begin : g_bht
            bht_2bit #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
                .clk       (clk),
                .rst       (rst),
                .rd_idx    (f_pc_s[IDX_W-1:0]),
                .rd_taken  (bht_taken_s),
                .upd_en    (bht_upd_s),
                .upd_idx   (bus.M_pc[IDX_W-1:0]),
                .upd_taken (bus.M_cnd)
            );
        end else begin : g_static
            assign bht_taken_s = 1'b1;
        end
    endgenerate

    assign unused_s = ^{bus.M_pc, bht_upd_s};

    // While halted only a redirect lets new instructions into D
    assign load_s   = !bus.D_stall && !bus.D_bubble && (!halted_r || redirect_s);
    assign bubble_s = !bus.D_stall && !load_s;

    // Predicted-PC register and sticky halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc_r <= RESET_PC;
            halted_r  <= 1'b0;
        end else begin
            if (!bus.F_stall && (!halted_r || redirect_s)) pred_pc_r <= pred_next_s;
            if (load_s) begin
                halted_r <= (stat_s != STAT_AOK);
            end else if (redirect_s) begin
                halted_r <= 1'b0;
            end
        end
    end

    // D pipeline register: hold, bubble or load the decoded instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!rst && bubble_s)) begin
            bus.D_icode      <= BUBBLE_ICODE;
            bus.D_ifun       <= BUBBLE_IFUN;
            bus.D_rA         <= R_NONE;
            bus.D_rB         <= R_NONE;
            bus.D_valC       <= {ADDR_W{1'b0}};
            bus.D_valP       <= {ADDR_W{1'b0}};
            bus.D_pc         <= {ADDR_W{1'b0}};
            bus.D_alt_pc     <= {ADDR_W{1'b0}};
            bus.D_pred_taken <= 1'b0;
            bus.D_stat       <= STAT_AOK;
        end else if (load_s) begin
            bus.D_icode      <= icode_s;
            bus.D_ifun       <= ifun_s;
            bus.D_rA         <= ra_s;
            bus.D_rB         <= rb_s;
            bus.D_valC       <= valc_s;
            bus.D_valP       <= valp_s;
            bus.D_pc         <= f_pc_s;
            bus.D_alt_pc     <= alt_pc_s;
            bus.D_pred_taken <= pred_taken_s;
            bus.D_stat       <= stat_s;
        end
    end
endmodule

// File: tb/tb_fetch_pred_64.sv
// Directed bench for fetch_pred_64: stimulus pushes hand-computed
// expectations into a scoreboard queue, a negedge monitor compares them.
module tb_fetch_pred_64;
    localparam int ADDR_W = 64;
    localparam int S_FPC = 0, S_ICODE = 1, S_IFUN = 2, S_RA = 3, S_RB = 4, S_VALC = 5,
                   S_VALP = 6, S_PC = 7, S_ALT = 8, S_PT = 9, S_STAT = 10;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem [0:1023];
    chk_t        sb_q [$];
    chk_t        cur;
    logic [63:0] act_v;
    int          checks = 0;
    int          errors = 0;

    fetch_pred_64_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_pred_64 #(
        .ADDR_W(ADDR_W), .IMEM_BYTES(1024), .RESET_PC(64'h0),
        .PRED_MODE(1), .BHT_ENTRIES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.instr_bytes = 80'h0;
        for (int k = 0; k < 10; k++) begin
            logic [63:0] a;
            a = bus.f_pc + 64'(k);
            bus.instr_bytes[8*k +: 8] = (a < 64'd1024) ? mem[a[9:0]] : 8'h00;
        end
    end

    function automatic logic [63:0] dut_val(input int sel);
        case (sel)
            S_FPC:   dut_val = bus.f_pc;
            S_ICODE: dut_val = {60'h0, bus.D_icode};
            S_IFUN:  dut_val = {60'h0, bus.D_ifun};
            S_RA:    dut_val = {60'h0, bus.D_rA};
            S_RB:    dut_val = {60'h0, bus.D_rB};
            S_VALC:  dut_val = bus.D_valC;
            S_VALP:  dut_val = bus.D_valP;
            S_PC:    dut_val = bus.D_pc;
            S_ALT:   dut_val = bus.D_alt_pc;
            S_PT:    dut_val = {63'h0, bus.D_pred_taken};
            S_STAT:  dut_val = {60'h0, bus.D_stat};
            default: dut_val = 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    // Monitor: outputs are stable at the falling edge, drain every pending check
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur   = sb_q.pop_front();
            act_v = dut_val(cur.sel);
            checks++;
            if (act_v !== cur.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", cur.name, act_v, cur.exp);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [63:0] exp, input string name);
        chk_t c;
        c.sel = sel; c.exp = exp; c.name = name;
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [3:0] icode, input logic [3:0] ifun, input logic cnd,
                         input logic pt, input logic [63:0] alt, input logic [63:0] pc);
        bus.M_icode = icode; bus.M_ifun = ifun; bus.M_cnd = cnd;
        bus.M_pred_taken = pt; bus.M_alt_pc = alt; bus.M_pc = pc;
    endtask

    task automatic redirect(input logic [63:0] target);
        set_m(4'h7, 4'h0, 1'b1, 1'b0, target, 64'h0);
    endtask

    task automatic m_idle();
        set_m(4'h1, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [79:0] irm;
        logic [71:0] jne;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
        irm = 80'h1122334455667788_F3_30;
        jne = 72'h0000000000000100_74;
        for (int k = 0; k < 10; k++) mem[k] = irm[8*k +: 8];
        for (int k = 0; k < 9; k++) mem[32'h20 + k] = jne[8*k +: 8];
        mem[1022] = 8'h30;
        mem[1023] = 8'hF3;

        bus.F_stall = 1'b0; bus.D_stall = 1'b0; bus.D_bubble = 1'b0;
        bus.W_icode = 4'h1; bus.W_valM = 64'h0;
        m_idle();

        // Reset state
        tick(); tick();
        expect_v(S_ICODE, 64'h1, "rst_icode");
        expect_v(S_RA, 64'hF, "rst_rA");
        expect_v(S_RB, 64'hF, "rst_rB");
        expect_v(S_STAT, 64'h1, "rst_stat");
        expect_v(S_VALP, 64'h0, "rst_valP");
        expect_v(S_PT, 64'h0, "rst_pt");
        expect_v(S_FPC, 64'h0, "rst_fpc");
        rst = 1'b0;

        // irmovq at 0
        tick();
        expect_v(S_ICODE, 64'h3, "irm_icode");
        expect_v(S_IFUN, 64'h0, "irm_ifun");
        expect_v(S_RA, 64'hF, "irm_rA");
        expect_v(S_RB, 64'h3, "irm_rB");
        expect_v(S_VALC, 64'h1122334455667788, "irm_valC");
        expect_v(S_VALP, 64'd10, "irm_valP");
        expect_v(S_ALT, 64'd10, "irm_alt");
        expect_v(S_STAT, 64'h1, "irm_stat");
        expect_v(S_FPC, 64'd10, "irm_fpc");

        // jne at 0x20, counter starts weakly taken
        tick();
        redirect(64'h20);
        expect_v(S_FPC, 64'h20, "redir_fpc");
        tick();
        set_m(4'h7, 4'h4, 1'b0, 1'b0, 64'h0, 64'h20);
        expect_v(S_ICODE, 64'h7, "jne_icode");
        expect_v(S_IFUN, 64'h4, "jne_ifun");
        expect_v(S_PC, 64'h20, "jne_pc");
        expect_v(S_VALC, 64'h100, "jne_valC");
        expect_v(S_PT, 64'h1, "jne_pt_init");
        expect_v(S_ALT, 64'h29, "jne_alt_init");
        expect_v(S_FPC, 64'h100, "jne_fpc_init");
        tick(); tick(); tick();
        redirect(64'h20);
        expect_v(S_FPC, 64'h20, "redir2_fpc");
        tick();
        m_idle();
        expect_v(S_PT, 64'h0, "jne_pt_trained");
        expect_v(S_ALT, 64'h100, "jne_alt_trained");
        expect_v(S_VALP, 64'h29, "jne_valP");
        expect_v(S_FPC, 64'h29, "jne_fpc_trained");

        // Mispredict beats RET, then RET alone
        tick();
        redirect(64'h40);
        bus.W_icode = 4'h9; bus.W_valM = 64'h80;
        expect_v(S_FPC, 64'h40, "mp_ret_fpc");
        tick();
        m_idle();
        expect_v(S_PC, 64'h40, "mp_ret_dpc");
        expect_v(S_FPC, 64'h80, "ret_fpc");
        tick();
        bus.W_icode = 4'h1;

        // Out-of-bounds fetch, sticky halt, redirect recovery
        redirect(64'h3FE);
        expect_v(S_PC, 64'h80, "ret_dpc");
        expect_v(S_FPC, 64'h3FE, "adr_fpc");
        tick();
        m_idle();
        expect_v(S_STAT, 64'h4, "adr_stat");
        expect_v(S_ICODE, 64'h3, "adr_icode");
        expect_v(S_VALP, 64'h408, "adr_valP");
        expect_v(S_FPC, 64'h408, "adr_fpc_next");
        tick();
        expect_v(S_ICODE, 64'h1, "halt_bubble_icode");
        expect_v(S_PC, 64'h0, "halt_bubble_pc");
        expect_v(S_STAT, 64'h1, "halt_bubble_stat");
        expect_v(S_FPC, 64'h408, "halt_frozen1");
        tick();
        expect_v(S_FPC, 64'h408, "halt_frozen2");
        tick();
        redirect(64'h0);
        expect_v(S_FPC, 64'h0, "recover_fpc");
        tick();
        m_idle();
        expect_v(S_ICODE, 64'h3, "recover_icode");
        expect_v(S_STAT, 64'h1, "recover_stat");
        expect_v(S_FPC, 64'd10, "recover_fpc_next");
        tick();
        expect_v(S_PC, 64'd10, "resume_dpc");
        expect_v(S_FPC, 64'd11, "resume_fpc");

        // F_stall + D_bubble, then D_stall + D_bubble
        bus.F_stall = 1'b1; bus.D_bubble = 1'b1;
        tick();
        bus.F_stall = 1'b0; bus.D_bubble = 1'b0;
        expect_v(S_PC, 64'h0, "bubble_pc");
        expect_v(S_VALP, 64'h0, "bubble_valP");
        expect_v(S_ICODE, 64'h1, "bubble_icode");
        expect_v(S_FPC, 64'd11, "fstall_fpc");
        tick();
        bus.D_stall = 1'b1; bus.D_bubble = 1'b1;
        expect_v(S_PC, 64'd11, "load_pc");
        expect_v(S_FPC, 64'd12, "load_fpc");
        tick();
        bus.D_stall = 1'b0; bus.D_bubble = 1'b0;
        expect_v(S_PC, 64'd11, "hold_pc");
        expect_v(S_VALP, 64'd12, "hold_valP");
        expect_v(S_FPC, 64'd13, "hold_fpc");

        // Asynchronous reset between edges
        tick();
        #2;
        rst = 1'b1;
        expect_v(S_PC, 64'h0, "arst_pc");
        expect_v(S_ICODE, 64'h1, "arst_icode");
        expect_v(S_RA, 64'hF, "arst_rA");
        expect_v(S_STAT, 64'h1, "arst_stat");
        expect_v(S_FPC, 64'h0, "arst_fpc");
        tick();
        rst = 1'b0;
        redirect(64'h20);
        expect_v(S_FPC, 64'h20, "post_rst_redir");
        tick();
        m_idle();
        expect_v(S_PT, 64'h1, "bht_reset_pt");
        expect_v(S_ALT, 64'h29, "bht_reset_alt");
        expect_v(S_FPC, 64'h100, "bht_reset_fpc");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
